// File: rtl/gcd_pkg.sv
// Shared types and helpers for the binary (Stein) GCD unit.
//   state_t : controller states (WAIT, STRIP, REDUCE, DONE)
//   op_t    : datapath operation selected by the controller each cycle
//   abs_s64 : magnitude of a sign-extended operand (supports operand widths up to 64 bits)
package gcd_pkg;

  localparam int unsigned MaxWidth = 64;

  typedef enum logic [1:0] {
    WAIT   = 2'd0,
    STRIP  = 2'd1,
    REDUCE = 2'd2,
    DONE   = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    OpHold      = 3'd0,
    OpLoad      = 3'd1,
    OpHalveBoth = 3'd2,
    OpHalveU    = 3'd3,
    OpHalveV    = 3'd4,
    OpSubU      = 3'd5,
    OpSubV      = 3'd6
  } op_t;

  // Negating the most-negative N-bit value is safe here because the argument is
  // sign-extended to 64 bits first; the caller truncates back to N bits.
  function automatic logic [MaxWidth-1:0] abs_s64(input logic signed [MaxWidth-1:0] x);
    logic signed [MaxWidth-1:0] neg;
    neg = -x;
    return x[MaxWidth-1] ? neg : x;
  endfunction

endpackage

// File: rtl/gcd_binary_datapath.sv
// Datapath for the binary GCD unit: operand registers u/v, shift count k,
// the single subtractor, the shifters and the status flags.
//   clk, reset   : clock, asynchronous active-high reset
//   op_i         : operation to apply at the next edge
//   a_i, b_i     : signed operands, loaded as magnitudes on OpLoad
//   zero_o       : u == 0 or v == 0
//   u_even_o     : u is even
//   v_even_o     : v is even
//   ge_o         : u >= v
//   result_o     : (u | v) << k, the GCD once zero_o is set
module gcd_binary_datapath
  import gcd_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  op_t          op_i,
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic         zero_o,
  output logic         u_even_o,
  output logic         v_even_o,
  output logic         ge_o,
  output logic [N-1:0] result_o
);

  localparam int unsigned KW = $clog2(N) + 1;

  logic [N-1:0]  u_q, u_d;
  logic [N-1:0]  v_q, v_d;
  logic [KW-1:0] k_q, k_d;

  logic [N-1:0] sub_l, sub_r, diff;

  assign zero_o   = (u_q == '0) || (v_q == '0);
  assign u_even_o = ~u_q[0];
  assign v_even_o = ~v_q[0];
  assign ge_o     = (u_q >= v_q);
  assign result_o = (u_q | v_q) << k_q;

  // One subtractor; operands are ordered so the difference is never negative.
  assign sub_l = ge_o ? u_q : v_q;
  assign sub_r = ge_o ? v_q : u_q;
  assign diff  = sub_l - sub_r;

  always_comb begin
    u_d = u_q;
    v_d = v_q;
    k_d = k_q;
    unique case (op_i)
      OpLoad: begin
        u_d = N'(abs_s64(64'($signed(a_i))));
        v_d = N'(abs_s64(64'($signed(b_i))));
        k_d = '0;
      end
      OpHalveBoth: begin
        u_d = u_q >> 1;
        v_d = v_q >> 1;
        k_d = k_q + KW'(1);
      end
      OpHalveU: u_d = u_q >> 1;
      OpHalveV: v_d = v_q >> 1;
      OpSubU:   u_d = diff >> 1;
      OpSubV:   v_d = diff >> 1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      u_q <= '0;
      v_q <= '0;
      k_q <= '0;
    end else begin
      u_q <= u_d;
      v_q <= v_d;
      k_q <= k_d;
    end
  end

endmodule

// File: rtl/gcd_binary.sv
// Binary (Stein) GCD of two signed N-bit operands, result gcd(|a|,|b|) unsigned.
// Controller FSM and step counter; arithmetic lives in gcd_binary_datapath.
//   clk, reset        : clock, asynchronous active-high reset
//   a, b              : signed operands, sampled when idle && input_available
//   input_available   : operands valid
//   result_taken      : consumer accepts the result (honoured in DONE only)
//   idle              : ready for operands
//   result_available  : out/steps valid
//   out               : gcd, held until the next result
//   steps             : STRIP+REDUCE cycles used, saturating at 2^CW-1
module gcd_binary
  import gcd_pkg::*;
#(
  parameter int unsigned N  = 8,
  parameter int unsigned CW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  a,
  input  logic [N-1:0]  b,
  input  logic          input_available,
  input  logic          result_taken,
  output logic          idle,
  output logic          result_available,
  output logic [N-1:0]  out,
  output logic [CW-1:0] steps
);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [N-1:0]  out_q, out_d;
  logic [CW-1:0] steps_q, steps_d;

  op_t          op;
  logic         zero, u_even, v_even, ge;
  logic [N-1:0] result;

  gcd_binary_datapath #(
    .N (N)
  ) u_datapath (
    .clk      (clk),
    .reset    (reset),
    .op_i     (op),
    .a_i      (a),
    .b_i      (b),
    .zero_o   (zero),
    .u_even_o (u_even),
    .v_even_o (v_even),
    .ge_o     (ge),
    .result_o (result)
  );

  // Count of the current cycle, so the terminating cycle is included in steps.
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CW'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    steps_d = steps_q;
    op      = OpHold;
    unique case (state_q)
      WAIT: begin
        if (input_available) begin
          op      = OpLoad;
          cnt_d   = '0;
          state_d = STRIP;
        end
      end
      STRIP: begin
        cnt_d = cnt_inc;
        if (zero) begin
          out_d   = result;
          steps_d = cnt_inc;
          state_d = DONE;
        end else if (u_even && v_even) begin
          op = OpHalveBoth;
        end else begin
          state_d = REDUCE;
        end
      end
      REDUCE: begin
        cnt_d = cnt_inc;
        if (zero) begin
          out_d   = result;
          steps_d = cnt_inc;
          state_d = DONE;
        end else if (u_even) begin
          op = OpHalveU;
        end else if (v_even) begin
          op = OpHalveV;
        end else if (ge) begin
          op = OpSubU;
        end else begin
          op = OpSubV;
        end
      end
      DONE: begin
        if (result_taken) state_d = WAIT;
      end
      default: state_d = WAIT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= WAIT;
      cnt_q   <= '0;
      out_q   <= '0;
      steps_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      steps_q <= steps_d;
    end
  end

  assign idle             = (state_q == WAIT);
  assign result_available = (state_q == DONE);
  assign out              = out_q;
  assign steps            = steps_q;

endmodule
